// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled LED pattern stepper (rotate left/right, bounce, up-count).
module led_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int DIV = 25_000_000,
  parameter logic [WIDTH-1:0] INIT = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             pause,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] led,
  output logic             tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  logic dir;
  logic step, go_right;
  logic [WIDTH-1:0] nxt, rol, ror, bnc;
  assign step = (cnt == CW'(DIV - 1)) && !pause;
  // dir: 0 = LEFT, 1 = RIGHT; hitting the edge in the travel direction flips it
  always_comb begin
    rol = {led[WIDTH-2:0], led[WIDTH-1]};
    ror = {led[0], led[WIDTH-1:1]};
    go_right = dir ^ (dir ? led[0] : led[WIDTH-1]);
    bnc = go_right ? led >> 1 : led << 1;
    nxt = mode == 2'b00 ? rol : mode == 2'b01 ? ror : mode == 2'b10 ? bnc : led + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= INIT;
      cnt <= '0;
      dir <= 1'b0;
      tick <= 1'b0;
    end else if (load) begin
      led <= data;
      cnt <= '0;
      dir <= 1'b0;
      tick <= 1'b0;
    end else begin
      tick <= step;
      if (!pause) cnt <= step ? '0 : cnt + 1'b1;
      if (step) begin
        led <= nxt;
        if (mode == 2'b10) dir <= go_right;
      end
    end
  end
endmodule
